rv32_instr_encoder: RTL and testbench
=====================================

# rv32_instr_encoder

Sequential RV32I instruction encoder producing the 32-bit instruction words that the core's decoder consumes. It accepts one symbolic instruction per handshake (kind, register fields, funct3, full 32-bit immediate), checks it for encodability and emits the packed word with its target address. The `LI` pseudo-instruction expands to one or two words. It sits between the bring-up/self-test program generator and the instruction-memory write port.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: address of the first emitted word.
- `clk_i` input 1: clock.
- `rst_i` input 1: synchronous reset, active-high.
- `in_valid_i` input 1: request valid.
- `in_ready_o` output 1: request accepted when high with `in_valid_i`.
- `in_kind_i` input 4: 0 R-type, 1 OP-IMM (non-shift), 2 SHIFT-IMM, 3 LOAD, 4 STORE, 5 BRANCH, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC, 10 LI; 11–15 are illegal.
- `in_funct3_i` input 3: funct3.
- `in_alt_i` input 1: sets instr[30] (SUB/SRA/SRAI); legal only for R funct3 000/101 and SHIFT-IMM funct3 101.
- `in_rd_i`, `in_rs1_i`, `in_rs2_i` input 5 each: register indices.
- `in_imm_i` input 32: full immediate value (byte offset for B/J; full 32-bit value for U/LI).
- `out_valid_o` output 1, `out_ready_i` input 1: output handshake.
- `out_instr_o` output 32: encoded word.
- `out_addr_o` output 32: address of `out_instr_o`.
- `out_last_o` output 1: final word of the current request.
- `err_o` output 1: one-cycle pulse for a rejected request.
- `err_code_o` output 2: 01 illegal kind/funct3/alt, 10 immediate out of range, 11 misaligned B/J offset. Holds its value until the next error.

## Operation
- States: IDLE, OUT (word held), OUT2 (second LI word held).
- `in_ready_o` = IDLE, or (OUT and `out_ready_i` and no second word pending). This path from `out_ready_i` is combinational and intentional.
- Legality checks:
  - LOAD funct3 must be one of {000,001,010,100,101}.
  - STORE funct3 must be ≤ 010.
  - BRANCH funct3 must not be 010 or 011.
  - JALR funct3 must be 000.
  - `in_alt_i` is ignored only for kinds where funct7 is not meaningful and rejected where it is illegal per the rule above.
- Immediate range checks:
  - I/S kinds: signed 12-bit range [-2048, 2047].
  - SHIFT-IMM: imm[31:5] = 0.
  - BRANCH: signed 13-bit range, imm[0] = 0.
  - JAL: signed 21-bit range, imm[0] = 0.
  - LUI/AUIPC: imm[11:0] = 0.
- Error handling: when a request fails a check, it is still accepted. No word is emitted, `err_o` pulses the next cycle, and the FSM stays in IDLE. If both a range error and an alignment error apply, code 11 takes precedence over 10.
- LI expansion:
  - If imm is in signed 12-bit range: emit one word, ADDI rd,x0,imm.
  - Otherwise: first word LUI rd,(imm+32'h800)>>12. If imm[11:0] ≠ 0, a second word ADDI rd,rd,sext(imm[11:0]) follows; if imm[11:0] = 0, only the LUI is emitted.
  - The addition wraps modulo 2^32.
- Output word registers hold stable while `out_valid_o` && !`out_ready_i`.
- `out_addr_o` increments by 4 on each output handshake and wraps at 2^32.
- Reset values: FSM IDLE, `out_valid_o` 0, `out_instr_o` 0, `out_addr_o` `BASE_ADDR`, `out_last_o` 0, `err_o` 0, `err_code_o` 00, `in_ready_o` 1.

## Timing
- Latency from request acceptance to `out_valid_o`: 1 cycle.
- Throughput: 1 word/cycle when `out_ready_i` is held high. An LI request that expands to two words blocks the input for one extra cycle.
- OUT2 is entered on the handshake of the first LI word. The second word is presented the following cycle with `out_last_o` = 1.
- Reset asserted mid-expansion discards the pending and held words; `out_addr_o` returns to `BASE_ADDR`.
- Simultaneous error request and output handshake in OUT: the held word completes normally and the FSM goes to IDLE; `err_o` pulses the next cycle.

## Test plan
- ADDI x1,x0,5 (kind 1, funct3 000, imm 5) -> `out_instr_o` 0x00500093, `out_addr_o` `BASE_ADDR`, `out_last_o` 1.
- R-type SUB x3,x1,x2 (`in_alt_i` 1) followed by JAL x1,+8 -> words 0x402081B3 then 0x008000EF, addresses `BASE_ADDR` and `BASE_ADDR`+4, produced on consecutive cycles.
- LI x5,0x12345FFF -> 0x123462B7 (`out_last_o` 0) then 0xFFF28293 (`out_last_o` 1). LI x5,0x00001000 -> single word 0x000012B7 with `out_last_o` 1.
- BRANCH imm 3 -> no output, `err_o` pulse with code 11. ADDI imm 2048 -> code 10. LOAD funct3 011 -> code 01. `out_addr_o` is unchanged in all three cases.
- Backpressure: hold `out_ready_i` low for 3 cycles during an LI -> word and address remain stable, `in_ready_o` is 0 throughout, and no words are lost or duplicated.
- Assert reset while in OUT2 -> next cycle `out_valid_o` is 0 and `out_addr_o` = `BASE_ADDR`; the next request encodes normally.

Source files
------------

// File: rtl/rv32_instr_encoder_if.sv
// Request/response bundle between the program generator and the RV32I encoder.
// The encoder takes the slave side; the generator (or bench) takes the master side.
interface rv32_instr_encoder_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  in_kind_i;
    logic [2:0]  in_funct3_i;
    logic        in_alt_i;
    logic [4:0]  in_rd_i;
    logic [4:0]  in_rs1_i;
    logic [4:0]  in_rs2_i;
    logic [31:0] in_imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_addr_o;
    logic        out_last_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    modport slave (
        input  in_valid_i, in_kind_i, in_funct3_i, in_alt_i, in_rd_i, in_rs1_i, in_rs2_i,
               in_imm_i, out_ready_i,
        output in_ready_o, out_valid_o, out_instr_o, out_addr_o, out_last_o, err_o, err_code_o
    );

    modport master (
        output in_valid_i, in_kind_i, in_funct3_i, in_alt_i, in_rd_i, in_rs1_i, in_rs2_i,
               in_imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_addr_o, out_last_o, err_o, err_code_o
    );
endinterface

// File: rtl/rv32_instr_encoder.sv
// Sequential RV32I encoder: one symbolic request in, one or two packed words out
// with their target addresses. Rejected requests produce a one-cycle error pulse.
module rv32_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic clk_i,
    input  logic rst_i,
    rv32_instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, OUT = 2'd1, OUT2 = 2'd2} state_t;

    localparam logic [3:0] K_R = 4'd0, K_OPIMM = 4'd1, K_SHIFT = 4'd2, K_LOAD = 4'd3,
                           K_STORE = 4'd4, K_BRANCH = 4'd5, K_JAL = 4'd6, K_JALR = 4'd7,
                           K_LUI = 4'd8, K_AUIPC = 4'd9, K_LI = 4'd10;

    localparam logic [6:0] OP_OP = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    state_t      state_q, state_d;
    logic [31:0] instr_q, pend_q, addr_q;
    logic        last_q, err_q;
    logic [1:0]  err_code_q;

    logic        in_ready, out_valid, accept, out_fire;
    logic        illegal, range_err, align_err, bad, two_words;
    logic [1:0]  err_code;
    logic [31:0] word1, word2;
    logic        fits12, fits13, fits21;
    logic [19:0] lui_hi;

    // Short aliases for the request fields.
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    assign f3  = bus.in_funct3_i;
    assign alt = bus.in_alt_i;
    assign rd  = bus.in_rd_i;
    assign rs1 = bus.in_rs1_i;
    assign rs2 = bus.in_rs2_i;
    assign imm = bus.in_imm_i;

    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);
    // (imm + 0x800) >> 12: adding 0x800 carries into bit 12 exactly when imm[11] is set.
    assign lui_hi = imm[31:12] + {19'd0, imm[11]};

    // Legality, range checks and word packing for the presented request.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        illegal   = 1'b0;
        range_err = 1'b0;
        align_err = 1'b0;
        two_words = 1'b0;
        word1     = '0;
        word2     = {imm[11:0], rd, 3'b000, rd, OP_IMM};
        case (bus.in_kind_i)
            K_R: begin
                illegal = alt && !(f3 == 3'b000 || f3 == 3'b101);
                word1   = {1'b0, alt, 5'd0, rs2, rs1, f3, rd, OP_OP};
            end
            K_OPIMM: begin
                range_err = !fits12;
                word1     = {imm[11:0], rs1, f3, rd, OP_IMM};
            end
            K_SHIFT: begin
                illegal   = alt && (f3 != 3'b101);
                range_err = |imm[31:5];
                word1     = {1'b0, alt, 5'd0, imm[4:0], rs1, f3, rd, OP_IMM};
            end
            K_LOAD: begin
                illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                range_err = !fits12;
                word1     = {imm[11:0], rs1, f3, rd, OP_LOAD};
            end
            K_STORE: begin
                illegal   = f3 > 3'b010;
                range_err = !fits12;
                word1     = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            end
            K_BRANCH: begin
                illegal   = (f3 == 3'b010) || (f3 == 3'b011);
                range_err = !fits13;
                align_err = imm[0];
                word1     = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            end
            K_JAL: begin
                range_err = !fits21;
                align_err = imm[0];
                word1     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            K_JALR: begin
                illegal   = f3 != 3'b000;
                range_err = !fits12;
                word1     = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            end
            K_LUI: begin
                range_err = |imm[11:0];
                word1     = {imm[31:12], rd, OP_LUI};
            end
            K_AUIPC: begin
                range_err = |imm[11:0];
                word1     = {imm[31:12], rd, OP_AUIPC};
            end
            K_LI: begin
                if (fits12) begin
                    word1 = {imm[11:0], 5'd0, 3'b000, rd, OP_IMM};
                end else begin
                    word1     = {lui_hi, rd, OP_LUI};
                    two_words = |imm[11:0];
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    // Error priority: illegal encoding, then misalignment over range.
    assign bad      = illegal | align_err | range_err;
    assign err_code = illegal ? 2'b01 : (align_err ? 2'b11 : (range_err ? 2'b10 : 2'b00));

    // FSM state register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !bad) state_d = OUT;
            OUT: begin
                if (bus.out_ready_i) begin
                    if (!last_q)             state_d = OUT2;
                    else if (accept && !bad) state_d = OUT;
                    else                     state_d = IDLE;
                end
            end
            OUT2: if (bus.out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the out_ready_i -> in_ready_o path is combinational on purpose.
    always_comb begin
        out_valid = state_q != IDLE;
        in_ready  = (state_q == IDLE) || (state_q == OUT && bus.out_ready_i && last_q);
    end

    assign accept   = bus.in_valid_i && in_ready;
    assign out_fire = out_valid && bus.out_ready_i;

    // Output word, pending LI word, address counter and error reporting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q    <= '0;
            pend_q     <= '0;
            addr_q     <= BASE_ADDR;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            err_q <= accept && bad;
            if (accept && bad) err_code_q <= err_code;
            if (out_fire)      addr_q     <= addr_q + 32'd4;
            if (accept && !bad) begin
                instr_q <= word1;
                pend_q  <= word2;
                last_q  <= !two_words;
            end else if (out_fire && !last_q) begin
                instr_q <= pend_q;
                last_q  <= 1'b1;
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_instr_o = instr_q;
    assign bus.out_addr_o  = addr_q;
    assign bus.out_last_o  = last_q;
    assign bus.err_o       = err_q;
    assign bus.err_code_o  = err_code_q;
endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Scoreboard bench for rv32_instr_encoder: expected words are queued as requests
// are driven and checked by a monitor when the encoder hands them off.
module tb_rv32_instr_encoder;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    localparam logic [3:0] K_R = 4'd0, K_OPIMM = 4'd1, K_SHIFT = 4'd2, K_LOAD = 4'd3,
                           K_STORE = 4'd4, K_BRANCH = 4'd5, K_JAL = 4'd6,
                           K_LUI = 4'd8, K_LI = 4'd10;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    word_t       sb[$];
    word_t       mon_exp;
    int          hs_q[$];
    logic [31:0] exp_addr = BASE;

    rv32_instr_encoder_if bus ();

    rv32_instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            hs_q.push_back(cyc);
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got instr=%h addr=%h last=%b, queue empty",
                         bus.out_instr_o, bus.out_addr_o, bus.out_last_o);
            end else begin
                mon_exp = sb.pop_front();
                if ({bus.out_instr_o, bus.out_addr_o, bus.out_last_o} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL word: got instr=%h addr=%h last=%b, want instr=%h addr=%h last=%b",
                             bus.out_instr_o, bus.out_addr_o, bus.out_last_o,
                             mon_exp.instr, mon_exp.addr, mon_exp.last);
                end
            end
        end
    end

    task automatic expect_word(input logic [31:0] instr, input logic last);
        sb.push_back('{instr: instr, addr: exp_addr, last: last});
        exp_addr = exp_addr + 32'd4;
    endtask

    // Present one request; called and returning at posedge+1.
    task automatic send(input logic [3:0] kind, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        int n = 0;
        bus.in_valid_i  = 1'b1;
        bus.in_kind_i   = kind;
        bus.in_funct3_i = f3;
        bus.in_alt_i    = alt;
        bus.in_rd_i     = rd;
        bus.in_rs1_i    = rs1;
        bus.in_rs2_i    = rs2;
        bus.in_imm_i    = imm;
        @(negedge clk);
        while (!bus.in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: kind=%0d imm=%h not accepted in 50 cycles", kind, imm);
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        while ((sb.size() != 0 || bus.out_valid_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (sb.size() != 0 || bus.out_valid_o) begin
            n_fail++;
            $display("FAIL drain: pending=%0d valid=%b, want pending=0 valid=0", sb.size(), bus.out_valid_o);
        end
        @(posedge clk);
        #1;
    endtask

    // Check the error pulse after a rejected request was accepted at the last edge.
    task automatic err_expect(input logic [1:0] code, input string name);
        @(negedge clk);
        n_checks++;
        if ({bus.err_o, bus.err_code_o, bus.out_valid_o, bus.out_addr_o} !== {1'b1, code, 1'b0, exp_addr}) begin
            n_fail++;
            $display("FAIL %s pulse: got err=%b code=%b valid=%b addr=%h, want err=1 code=%b valid=0 addr=%h",
                     name, bus.err_o, bus.err_code_o, bus.out_valid_o, bus.out_addr_o, code, exp_addr);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({bus.err_o, bus.err_code_o} !== {1'b0, code}) begin
            n_fail++;
            $display("FAIL %s hold: got err=%b code=%b, want err=0 code=%b", name, bus.err_o, bus.err_code_o, code);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid_o, bus.out_instr_o, bus.out_addr_o, bus.out_last_o, bus.err_o,
             bus.err_code_o, bus.in_ready_o} !== {1'b0, 32'h0, BASE, 1'b0, 1'b0, 2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset: got valid=%b instr=%h addr=%h last=%b err=%b code=%b ready=%b, want 0 0 %h 0 0 00 1",
                     bus.out_valid_o, bus.out_instr_o, bus.out_addr_o, bus.out_last_o, bus.err_o,
                     bus.err_code_o, bus.in_ready_o, BASE);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        expect_word(32'h00500093, 1'b1);
        send(K_OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        drain();
    endtask

    task automatic test_back_to_back();
        hs_q.delete();
        expect_word(32'h402081B3, 1'b1);
        expect_word(32'h008000EF, 1'b1);
        send(K_R, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        send(K_JAL, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        drain();
        n_checks++;
        if (hs_q.size() != 2 || hs_q[1] - hs_q[0] != 1) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d handshakes, gap=%0d, want 2 with gap 1",
                     hs_q.size(), (hs_q.size() == 2) ? hs_q[1] - hs_q[0] : -1);
        end
    endtask

    // Assorted formats, boundary immediates, LI expansions; addresses wrap past 2^32.
    task automatic test_formats();
        expect_word(32'h0020A423, 1'b1);
        send(K_STORE, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        expect_word(32'hFE208EE3, 1'b1);
        send(K_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        expect_word(32'h4071D213, 1'b1);
        send(K_SHIFT, 3'b101, 1'b1, 5'd4, 5'd3, 5'd0, 32'd7);
        expect_word(32'hABCDE3B7, 1'b1);
        send(K_LUI, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'hABCD_E000);
        expect_word(32'h80012303, 1'b1);
        send(K_LOAD, 3'b010, 1'b0, 5'd6, 5'd2, 5'd0, 32'hFFFF_F800);
        expect_word(32'h7FF00093, 1'b1);
        send(K_OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2047);
        expect_word(32'h00100113, 1'b1);
        send(K_OPIMM, 3'b000, 1'b1, 5'd2, 5'd0, 5'd0, 32'd1);
        expect_word(32'hFFF00293, 1'b1);
        send(K_LI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        expect_word(32'h123462B7, 1'b0);
        expect_word(32'hFFF28293, 1'b1);
        send(K_LI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        expect_word(32'h000012B7, 1'b1);
        send(K_LI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0000_1000);
        expect_word(32'h80001337, 1'b0);
        expect_word(32'h80030313, 1'b1);
        send(K_LI, 3'b000, 1'b0, 5'd6, 5'd0, 5'd0, 32'h8000_0800);
        drain();
    endtask

    task automatic test_errors();
        send(K_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
        err_expect(2'b11, "branch_misaligned");
        send(K_OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
        err_expect(2'b10, "addi_range");
        send(K_LOAD, 3'b011, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
        err_expect(2'b01, "load_funct3");
        send(4'd12, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
        err_expect(2'b01, "kind_illegal");
        send(K_JAL, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
        err_expect(2'b10, "jal_range");
        send(K_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4097);
        err_expect(2'b11, "branch_both");
        send(K_R, 3'b001, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        err_expect(2'b01, "r_alt");
        send(K_STORE, 3'b011, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0);
        err_expect(2'b01, "store_funct3");
        drain();
    endtask

    // Rejected request accepted on the same edge the held word completes.
    task automatic test_err_with_handshake();
        bus.out_ready_i = 1'b0;
        expect_word(32'h00500093, 1'b1);
        send(K_OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        bus.out_ready_i = 1'b1;
        send(K_OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F7FF);
        err_expect(2'b10, "err_handshake");
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] a0;
        bus.out_ready_i = 1'b0;
        a0 = exp_addr;
        expect_word(32'h123462B7, 1'b0);
        expect_word(32'hFFF28293, 1'b1);
        send(K_LI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.out_valid_o, bus.out_instr_o, bus.out_addr_o, bus.out_last_o, bus.in_ready_o}
                !== {1'b1, 32'h123462B7, a0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_%0d: got valid=%b instr=%h addr=%h last=%b ready=%b, want 1 123462b7 %h 0 0",
                         i, bus.out_valid_o, bus.out_instr_o, bus.out_addr_o, bus.out_last_o, bus.in_ready_o, a0);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_first_word: got in_ready=%b, want 0", bus.in_ready_o);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({bus.in_ready_o, bus.out_addr_o} !== {1'b0, a0 + 32'd4}) begin
            n_fail++;
            $display("FAIL ready_out2: got in_ready=%b addr=%h, want 0 %h", bus.in_ready_o, bus.out_addr_o, a0 + 32'd4);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_reset_in_out2();
        bus.out_ready_i = 1'b0;
        expect_word(32'h80001337, 1'b0);
        expect_word(32'h80030313, 1'b1);
        send(K_LI, 3'b000, 1'b0, 5'd6, 5'd0, 5'd0, 32'h8000_0800);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid_o, bus.out_instr_o, bus.out_last_o, bus.in_ready_o} !== {1'b1, 32'h80030313, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL out2_hold: got valid=%b instr=%h last=%b ready=%b, want 1 80030313 1 0",
                     bus.out_valid_o, bus.out_instr_o, bus.out_last_o, bus.in_ready_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        exp_addr = BASE;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid_o, bus.out_addr_o, bus.in_ready_o} !== {1'b0, BASE, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_out2: got valid=%b addr=%h ready=%b, want 0 %h 1",
                     bus.out_valid_o, bus.out_addr_o, bus.in_ready_o, BASE);
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        expect_word(32'h00500093, 1'b1);
        send(K_OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        drain();
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_kind_i   = 4'd0;
        bus.in_funct3_i = 3'd0;
        bus.in_alt_i    = 1'b0;
        bus.in_rd_i     = 5'd0;
        bus.in_rs1_i    = 5'd0;
        bus.in_rs2_i    = 5'd0;
        bus.in_imm_i    = 32'd0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_formats();
        test_errors();
        test_err_with_handshake();
        test_backpressure();
        test_reset_in_out2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
